// File: rtl/tdm_demux_pkg.sv
// Shared types and defaults for the TDM demultiplexer.
package tdm_demux_pkg;

    localparam int unsigned DefNumCh  = 4;
    localparam int unsigned DefDataW  = 8;
    localparam int unsigned ErrCntW   = 8;

    typedef enum logic [0:0] {
        StHunt,
        StLocked
    } state_e;

    function automatic int unsigned ch_idx_w(input int unsigned num_ch);
        return (num_ch > 2) ? $clog2(num_ch) : 1;
    endfunction

endpackage

// File: rtl/tdm_demux_bank.sv
// Staging registers for channels 0..NUM_CH-2 of the frame being assembled.
module tdm_demux_bank
    import tdm_demux_pkg::*;
#(
    parameter int unsigned NUM_CH = DefNumCh,
    parameter int unsigned DATA_W = DefDataW
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            we_i,
    input  logic [ch_idx_w(NUM_CH)-1:0]     idx_i,
    input  logic [DATA_W-1:0]               data_i,
    output logic [(NUM_CH-1)*DATA_W-1:0]    stage_o
);

    localparam int unsigned CH_W = ch_idx_w(NUM_CH);

    logic [DATA_W-1:0] stage_q [NUM_CH-1];
    logic [DATA_W-1:0] stage_d [NUM_CH-1];

    always_comb begin
        for (int i = 0; i < int'(NUM_CH) - 1; i++) begin
            stage_d[i] = stage_q[i];
            if (we_i && (idx_i == CH_W'(i))) begin
                stage_d[i] = data_i;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < int'(NUM_CH) - 1; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(NUM_CH) - 1; i++) begin
                stage_q[i] <= stage_d[i];
            end
        end
    end

    always_comb begin
        stage_o = '0;
        for (int i = 0; i < int'(NUM_CH) - 1; i++) begin
            stage_o[i*DATA_W +: DATA_W] = stage_q[i];
        end
    end

endmodule

// File: rtl/tdm_demux.sv
// TDM demultiplexer: serial samples with SOF marker -> registered parallel frame.
// Optional saturating error counter output err_cnt when TDM_DEMUX_ERRCNT_EN is defined.
module tdm_demux
    import tdm_demux_pkg::*;
#(
    parameter int unsigned NUM_CH = DefNumCh,
    parameter int unsigned DATA_W = DefDataW
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          in_valid,
    input  logic                          in_sof,
    input  logic [DATA_W-1:0]             in_data,
    output logic [NUM_CH*DATA_W-1:0]      out_data,
    output logic                          out_valid,
    output logic [ch_idx_w(NUM_CH)-1:0]   ch_idx,
    output logic                          locked,
`ifdef TDM_DEMUX_ERRCNT_EN
    output logic [ErrCntW-1:0]            err_cnt,
`endif
    output logic                          sync_err
);

    localparam int unsigned CH_W = ch_idx_w(NUM_CH);
    localparam logic [CH_W-1:0] LastIdx = CH_W'(NUM_CH - 1);

    state_e                     state_q, state_d;
    logic [CH_W-1:0]            ch_idx_q, ch_idx_d;
    logic [NUM_CH*DATA_W-1:0]   out_data_q, out_data_d;
    logic                       out_valid_q, out_valid_d;
    logic                       sync_err_q, sync_err_d;
    logic                       bank_we;
    logic [CH_W-1:0]            bank_idx;
    logic [(NUM_CH-1)*DATA_W-1:0] stage;

    tdm_demux_bank #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W)
    ) u_bank (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .we_i    (bank_we),
        .idx_i   (bank_idx),
        .data_i  (in_data),
        .stage_o (stage)
    );

    always_comb begin
        state_d     = state_q;
        ch_idx_d    = ch_idx_q;
        out_data_d  = out_data_q;
        out_valid_d = 1'b0;
        sync_err_d  = 1'b0;
        bank_we     = 1'b0;
        bank_idx    = ch_idx_q;

        if (in_valid) begin
            unique case (state_q)
                StHunt: begin
                    if (in_sof) begin
                        bank_we  = 1'b1;
                        bank_idx = '0;
                        ch_idx_d = CH_W'(1);
                        state_d  = StLocked;
                    end
                end
                StLocked: begin
                    if (in_sof) begin
                        // Early SOF restarts the frame; the partial one is abandoned.
                        bank_we    = 1'b1;
                        bank_idx   = '0;
                        ch_idx_d   = CH_W'(1);
                        sync_err_d = (ch_idx_q != '0);
                    end else if (ch_idx_q == '0) begin
                        sync_err_d = 1'b1;
                        state_d    = StHunt;
                    end else if (ch_idx_q == LastIdx) begin
                        out_data_d  = {in_data, stage};
                        out_valid_d = 1'b1;
                        ch_idx_d    = '0;
                    end else begin
                        bank_we  = 1'b1;
                        ch_idx_d = ch_idx_q + CH_W'(1);
                    end
                end
                default: state_d = StHunt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StHunt;
            ch_idx_q    <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            ch_idx_q    <= ch_idx_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            sync_err_q  <= sync_err_d;
        end
    end

`ifdef TDM_DEMUX_ERRCNT_EN
    logic [ErrCntW-1:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (sync_err_d && (err_cnt_q != '1)) begin
            err_cnt_d = err_cnt_q + ErrCntW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign ch_idx    = ch_idx_q;
    assign locked    = (state_q == StLocked);
    assign sync_err  = sync_err_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Directed self-checking bench for tdm_demux (NUM_CH=4, DATA_W=8).
module tb_tdm_demux;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_sof;
    logic [7:0]  in_data;
    logic [31:0] out_data;
    logic        out_valid;
    logic [1:0]  ch_idx;
    logic        locked;
    logic        sync_err;
`ifdef TDM_DEMUX_ERRCNT_EN
    logic [7:0]  err_cnt;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    tdm_demux #(
        .NUM_CH (4),
        .DATA_W (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_sof    (in_sof),
        .in_data   (in_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .ch_idx    (ch_idx),
        .locked    (locked),
`ifdef TDM_DEMUX_ERRCNT_EN
        .err_cnt   (err_cnt),
`endif
        .sync_err  (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drive one beat at the falling edge; outputs seen afterwards reflect the previous beat.
    task automatic tick(input logic v, input logic s, input logic [7:0] d);
        @(negedge clk);
        in_valid = v;
        in_sof   = s;
        in_data  = d;
    endtask

    task automatic do_reset();
        @(negedge clk);
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = '0;
        rst_n    = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_data  = '0;
        repeat (3) @(negedge clk);
        check("rst_out_data", 64'(out_data), 64'h0);
        check("rst_out_valid", 64'(out_valid), 64'h0);
        check("rst_ch_idx", 64'(ch_idx), 64'h0);
        check("rst_locked", 64'(locked), 64'h0);
        check("rst_sync_err", 64'(sync_err), 64'h0);
        rst_n = 1'b1;

        // Basic frame
        tick(1, 1, 8'h11);
        tick(1, 0, 8'h22);
        check("f1_locked", 64'(locked), 64'h1);
        check("f1_ch_idx1", 64'(ch_idx), 64'h1);
        tick(1, 0, 8'h33);
        tick(1, 0, 8'h44);
        check("f1_no_early_valid", 64'(out_valid), 64'h0);
        tick(0, 0, 8'h00);
        check("f1_out_data", 64'(out_data), 64'h44332211);
        check("f1_out_valid", 64'(out_valid), 64'h1);
        check("f1_sync_err", 64'(sync_err), 64'h0);
        check("f1_ch_idx0", 64'(ch_idx), 64'h0);
        tick(0, 0, 8'h00);
        check("f1_valid_one_cycle", 64'(out_valid), 64'h0);
        check("f1_hold", 64'(out_data), 64'h44332211);

        // Non-SOF data while hunting is dropped silently
        do_reset();
        tick(1, 0, 8'hAA);
        tick(0, 0, 8'h00);
        check("hunt_locked", 64'(locked), 64'h0);
        check("hunt_sync_err", 64'(sync_err), 64'h0);
        check("hunt_ch_idx", 64'(ch_idx), 64'h0);
        tick(1, 1, 8'h01);
        tick(1, 0, 8'h02);
        tick(1, 0, 8'h03);
        tick(1, 0, 8'h04);
        tick(0, 0, 8'h00);
        check("f2_out_data", 64'(out_data), 64'h04030201);
        check("f2_out_valid", 64'(out_valid), 64'h1);

        // Early SOF
        tick(1, 1, 8'h10);
        tick(1, 0, 8'h20);
        tick(1, 1, 8'h30);
        tick(1, 0, 8'h40);
        check("esof_sync_err", 64'(sync_err), 64'h1);
        check("esof_ch_idx", 64'(ch_idx), 64'h1);
        check("esof_locked", 64'(locked), 64'h1);
        check("esof_no_valid", 64'(out_valid), 64'h0);
        check("esof_hold", 64'(out_data), 64'h04030201);
        tick(1, 0, 8'h50);
        check("esof_err_pulse", 64'(sync_err), 64'h0);
        tick(1, 0, 8'h60);
        tick(0, 0, 8'h00);
        check("esof_out_data", 64'(out_data), 64'h60504030);
        check("esof_out_valid", 64'(out_valid), 64'h1);

        // Missing SOF after a complete frame
        tick(1, 0, 8'h77);
        tick(0, 0, 8'h00);
        check("msof_sync_err", 64'(sync_err), 64'h1);
        check("msof_locked", 64'(locked), 64'h0);
        check("msof_hold", 64'(out_data), 64'h60504030);
        tick(0, 0, 8'h00);
        check("msof_err_pulse", 64'(sync_err), 64'h0);

        // Gapped frame; sof without valid is ignored in the gaps
        tick(1, 1, 8'hA1);
        repeat (3) tick(0, 1, 8'hEE);
        tick(1, 0, 8'hA2);
        repeat (3) tick(0, 0, 8'h00);
        tick(1, 0, 8'hA3);
        repeat (3) tick(0, 0, 8'h00);
        check("gap_ch_idx", 64'(ch_idx), 64'h3);
        check("gap_no_valid", 64'(out_valid), 64'h0);
        tick(1, 0, 8'hA4);
        tick(0, 0, 8'h00);
        check("gap_out_data", 64'(out_data), 64'hA4A3A2A1);
        check("gap_out_valid", 64'(out_valid), 64'h1);
        check("gap_sync_err", 64'(sync_err), 64'h0);

        // Back-to-back frames: pulses exactly NUM_CH cycles apart
        tick(1, 1, 8'hB1);
        tick(1, 0, 8'hB2);
        tick(1, 0, 8'hB3);
        tick(1, 0, 8'hB4);
        tick(1, 1, 8'hC1);
        check("b2b_first_valid", 64'(out_valid), 64'h1);
        check("b2b_first_data", 64'(out_data), 64'hB4B3B2B1);
        tick(1, 0, 8'hC2);
        check("b2b_gap_valid", 64'(out_valid), 64'h0);
        tick(1, 0, 8'hC3);
        tick(1, 0, 8'hC4);
        tick(0, 0, 8'h00);
        check("b2b_second_valid", 64'(out_valid), 64'h1);
        check("b2b_second_data", 64'(out_data), 64'hC4C3C2C1);

        // Reset mid-frame
        tick(1, 1, 8'h55);
        tick(1, 0, 8'h66);
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        #1;
        check("mrst_out_data", 64'(out_data), 64'h0);
        check("mrst_locked", 64'(locked), 64'h0);
        check("mrst_ch_idx", 64'(ch_idx), 64'h0);
        check("mrst_out_valid", 64'(out_valid), 64'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick(1, 0, 8'h77);
        tick(1, 0, 8'h88);
        tick(1, 0, 8'h99);
        tick(1, 0, 8'hAB);
        tick(0, 0, 8'h00);
        check("mrst_needs_sof_locked", 64'(locked), 64'h0);
        check("mrst_needs_sof_valid", 64'(out_valid), 64'h0);
        check("mrst_needs_sof_data", 64'(out_data), 64'h0);

`ifdef TDM_DEMUX_ERRCNT_EN
        do_reset();
        check("errcnt_rst", 64'(err_cnt), 64'h0);
        // First SOF locks; each following SOF arrives with ch_idx=1 -> early SOF error
        for (int i = 0; i < 301; i++) begin
            tick(1, 1, 8'(i));
        end
        tick(0, 0, 8'h00);
        check("errcnt_sat", 64'(err_cnt), 64'hFF);
        tick(1, 1, 8'h00);
        tick(0, 0, 8'h00);
        check("errcnt_no_wrap", 64'(err_cnt), 64'hFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
